// File: rtl/rv_mem_pkg.sv
// Shared types and defaults for the data-memory access path.
// No logic: owner encoding and default bus widths only.
// No flow control of its own.
package rv_mem_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter (core/host) with host lock and last-owner register.
// Latency: grant is combinational, same cycle as request.
// Backpressure: a losing requester sees no grant and must hold its request.
module rr_arb2
    import rv_mem_pkg::*;
(
    input  logic clk,
    input  logic areset,
    input  logic req_core,
    input  logic req_host,
    input  logic lock,
    output logic gnt_core,
    output logic gnt_host
);

    owner_t last_owner_q;
    owner_t last_owner_d;

    // Pick the winner; lock hands the memory to the host, contention goes to whoever did not win last.
    always_comb begin
        gnt_core     = 1'b0;
        gnt_host     = 1'b0;
        last_owner_d = last_owner_q;
        if (areset) begin
            if (lock) begin
                gnt_host = req_host;
            end else if (req_core && req_host) begin
                if (last_owner_q == OWN_CORE) begin
                    gnt_host = 1'b1;
                end else begin
                    gnt_core = 1'b1;
                end
            end else begin
                gnt_core = req_core;
                gnt_host = req_host;
            end
        end
        if (gnt_host) begin
            last_owner_d = OWN_HOST;
        end else if (gnt_core) begin
            last_owner_d = OWN_CORE;
        end
    end

    // Remember the most recent winner; idle cycles leave it unchanged.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            last_owner_q <= OWN_CORE;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core LSU and the host port.
// Latency: grant same cycle; read data/rvalid one cycle after the granting edge.
// Backpressure: ungranted requester holds its request; core sees core_stall.
module dmem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  host_lock,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  core_stall
);

    logic   rd_pending_q;
    logic   rd_pending_d;
    owner_t rd_owner_q;
    owner_t rd_owner_d;

    rr_arb2 u_arb (
        .clk      (clk),
        .areset   (areset),
        .req_core (core_req),
        .req_host (host_req),
        .lock     (host_lock),
        .gnt_core (core_gnt),
        .gnt_host (host_gnt)
    );

    // Steer the granted port onto the memory; idle cycles park on the core's address/data.
    always_comb begin
        mem_en    = core_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (core_gnt) begin
            mem_we = core_we;
        end
    end

    // Track who issued this cycle's read so next cycle's data is flagged to that port only.
    always_comb begin
        rd_pending_d = mem_en & ~mem_we;
        rd_owner_d   = rd_owner_q;
        if (host_gnt) begin
            rd_owner_d = OWN_HOST;
        end else if (core_gnt) begin
            rd_owner_d = OWN_CORE;
        end
    end

    // Read-response register; reset drops any read in flight.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= OWN_CORE;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign core_rvalid = rd_pending_q & (rd_owner_q == OWN_CORE);
    assign host_rvalid = rd_pending_q & (rd_owner_q == OWN_HOST);
    assign core_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;
    // Reset gates the stall too, so a held core request does not read as a stall during reset.
    assign core_stall  = areset & core_req & ~core_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then constrained-random traffic.
// Expectations come from a request-level model of arbitration and memory contents.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
module tb_dmem_arbiter;

    logic        clk;
    logic        areset;
    logic        core_req, core_we, host_req, host_we, host_lock;
    logic [31:0] core_addr, core_wdata, host_addr, host_wdata;
    logic        core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic [31:0] core_rdata, host_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        core_stall;

    int tests = 0;
    int fails = 0;

    // Behavioural memory behind the arbiter (8 words).
    logic [31:0] tb_mem [8];

    // Reference model state.
    logic [31:0] exp_mem [8];
    logic        exp_last_host;
    logic        exp_rv_c, exp_rv_h;
    logic [31:0] exp_rdata;
    logic        obs_gc, obs_gh, obs_stall;

    dmem_arbiter dut (
        .clk         (clk),
        .areset      (areset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_lock   (host_lock),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .core_stall  (core_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr[4:2]] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr[4:2]];
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d;
    endtask

    task automatic set_host(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        host_req = r; host_we = w; host_addr = a; host_wdata = d;
    endtask

    task automatic model_reset();
        exp_last_host = 1'b0;
        exp_rv_c      = 1'b0;
        exp_rv_h      = 1'b0;
    endtask

    // One clock cycle: check all outputs against the model, then advance model and clock.
    task automatic cycle();
        logic        eg_c, eg_h, ewe;
        logic [31:0] eaddr, ewd;
        #1;
        eg_c = 1'b0;
        eg_h = 1'b0;
        if (host_lock)                eg_h = host_req;
        else if (core_req && host_req) begin
            if (exp_last_host) eg_c = 1'b1;
            else               eg_h = 1'b1;
        end else begin
            eg_c = core_req;
            eg_h = host_req;
        end
        ewe   = eg_h ? host_we    : (eg_c ? core_we : 1'b0);
        eaddr = eg_h ? host_addr  : core_addr;
        ewd   = eg_h ? host_wdata : core_wdata;

        obs_gc    = core_gnt;
        obs_gh    = host_gnt;
        obs_stall = core_stall;
        chk1("core_gnt", core_gnt, eg_c);
        chk1("host_gnt", host_gnt, eg_h);
        chk1("core_stall", core_stall, core_req & ~eg_c);
        chk1("mem_en", mem_en, eg_c | eg_h);
        chk1("mem_we", mem_we, ewe);
        chk32("mem_addr", mem_addr, eaddr);
        chk32("mem_wdata", mem_wdata, ewd);
        chk1("core_rvalid", core_rvalid, exp_rv_c);
        chk1("host_rvalid", host_rvalid, exp_rv_h);
        if (exp_rv_c) chk32("core_rdata", core_rdata, exp_rdata);
        if (exp_rv_h) chk32("host_rdata", host_rdata, exp_rdata);

        exp_rv_c = eg_c & ~ewe;
        exp_rv_h = eg_h & ~ewe;
        if ((eg_c | eg_h) && !ewe) exp_rdata = exp_mem[eaddr[4:2]];
        if ((eg_c | eg_h) && ewe)  exp_mem[eaddr[4:2]] = ewd;
        if (eg_h)      exp_last_host = 1'b1;
        else if (eg_c) exp_last_host = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] pat;
        logic [2:0] a3;
        for (int i = 0; i < 8; i++) begin
            tb_mem[i]  = 32'h0;
            exp_mem[i] = 32'h0;
        end
        exp_rdata = 32'h0;
        model_reset();

        // Reset held with both ports requesting.
        areset = 1'b0;
        host_lock = 1'b0;
        set_core(1'b1, 1'b0, 32'h0, 32'h0);
        set_host(1'b1, 1'b0, 32'h4, 32'h0);
        #1;
        chk1("rst_core_gnt", core_gnt, 1'b0);
        chk1("rst_host_gnt", host_gnt, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_stall", core_stall, 1'b0);
        @(posedge clk);
        #1;
        chk1("rst_core_rv", core_rvalid, 1'b0);
        chk1("rst_host_rv", host_rvalid, 1'b0);
        chk1("rst_mem_en2", mem_en, 1'b0);
        areset = 1'b1;

        // Continuous read contention: host wins first, then strict alternation.
        pat = 6'b010101;    // bit i = 1 means host expected on cycle i
        for (int i = 0; i < 6; i++) begin
            set_core(1'b1, 1'b0, 32'h8, 32'h0);
            set_host(1'b1, 1'b0, 32'hC, 32'h0);
            cycle();
            chk1("contend_host_gnt", obs_gh, pat[i]);
            chk1("contend_stall", obs_stall, pat[i]);
        end

        // Core-only write then read back.
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        set_core(1'b1, 1'b1, 32'h0, 32'h78);
        cycle();
        chk1("core_wr_gnt", obs_gc, 1'b1);
        set_core(1'b1, 1'b0, 32'h0, 32'h0);
        cycle();
        chk1("core_rd_gnt", obs_gc, 1'b1);
        chk1("core_rd_rv", core_rvalid, 1'b1);
        chk32("core_rd_data", core_rdata, 32'h78);
        chk1("core_rd_host_rv", host_rvalid, 1'b0);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // Host lock: host wins every cycle, core stalls throughout.
        host_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_core(1'b1, 1'b0, 32'h4, 32'h0);
            set_host(1'b1, 1'b0, 32'h8, 32'h0);
            cycle();
            chk1("lock_host_gnt", obs_gh, 1'b1);
            chk1("lock_stall", obs_stall, 1'b1);
        end
        host_lock = 1'b0;
        cycle();
        chk1("unlock_core_gnt", obs_gc, 1'b1);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // Host readback of a value the core just wrote.
        set_core(1'b1, 1'b1, 32'h0, 32'd120);
        cycle();
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b1, 1'b0, 32'h0, 32'h0);
        cycle();
        chk1("readback_gnt", obs_gh, 1'b1);
        chk1("readback_rv", host_rvalid, 1'b1);
        chk32("readback_data", host_rdata, 32'd120);
        chk1("readback_core_rv", core_rvalid, 1'b0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // Reset pulse after a core read is granted but before its edge.
        set_core(1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("midrst_gnt", core_gnt, 1'b1);
        areset = 1'b0;
        core_req = 1'b0;
        #1;
        chk1("midrst_gnt_low", core_gnt, 1'b0);
        areset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        chk1("midrst_no_rv", core_rvalid, 1'b0);
        cycle();

        // Random traffic; each port holds its request until granted.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) host_lock = ~host_lock;
            if (!core_req && $urandom_range(0, 3) != 0) begin
                a3 = 3'($urandom_range(0, 7));
                set_core(1'b1, 1'($urandom_range(0, 1)), {27'b0, a3, 2'b00}, $urandom);
            end
            if (!host_req && $urandom_range(0, 3) != 0) begin
                a3 = 3'($urandom_range(0, 7));
                set_host(1'b1, 1'($urandom_range(0, 1)), {27'b0, a3, 2'b00}, $urandom);
            end
            cycle();
            if (obs_gc) core_req = 1'b0;
            if (obs_gh) host_req = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
